// File: rtl/capture_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : capture_dump_sequencer
//  Purpose  : Captures DEPTH converter samples on a UART 's' command and
//             dumps them as uppercase hex text lines ("<hex>\n\r"), pacing
//             each byte with GAP_CYCLES idle clocks. 'x' aborts.
//  Revision : 1.0 - initial release
// ============================================================================
module capture_dump_sequencer #(
  parameter int SAMPLE_W   = 24,
  parameter int DEPTH      = 4096,
  parameter int GAP_CYCLES = 5000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                rvalid,
  input  logic [7:0]          rdata,
  output logic                rready,
  output logic                tvalid,
  output logic [7:0]          tdata,
  input  logic                tready,
  output logic                busy,
  output logic                done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NIB = SAMPLE_W / 4;
  localparam int CW  = $clog2(NIB + 2);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AW-1:0] C_LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] C_CHAR_LF  = CW'(NIB);
  localparam logic [CW-1:0] C_CHAR_CR  = CW'(NIB + 1);
  localparam logic [GW-1:0] C_GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_GAP     = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_done_set;

  logic                r_rready;
  logic                r_done;
  logic                r_abort;      // abort seen while a byte is still on offer
  logic [AW-1:0]       r_wr_idx;
  logic [AW-1:0]       r_rd_idx;
  logic [CW-1:0]       r_char;
  logic [GW-1:0]       r_gap;
  logic [SAMPLE_W-1:0] r_rd_data;
  logic [SAMPLE_W-1:0] r_mem [DEPTH];

  logic                w_consume;
  logic                w_is_start;
  logic                w_is_abort;
  logic                w_hs;
  logic                w_wr_en;
  logic [3:0]          w_nib;
  logic [7:0]          w_char;

  assign w_consume  = rvalid & r_rready;
  assign w_is_start = w_consume & ((rdata == 8'h73) | (rdata == 8'h53));
  assign w_is_abort = w_consume & ((rdata == 8'h78) | (rdata == 8'h58));
  assign w_hs       = (r_state == ST_SEND) & tready;
  assign w_wr_en    = (r_state == ST_CAPTURE) & sample_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; an abort during SEND waits for the current handshake
  always_comb begin
    w_next_state = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_start) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_is_abort) begin
          w_next_state = ST_IDLE;
        end else if (sample_valid && (r_wr_idx == C_LAST_IDX)) begin
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_is_abort) begin
          w_next_state = ST_IDLE;
        end else if (r_gap == '0) begin
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          if (r_abort || w_is_abort) begin
            w_next_state = ST_IDLE;
          end else if ((r_char == C_CHAR_CR) && (r_rd_idx == C_LAST_IDX)) begin
            w_next_state = ST_IDLE;
            w_done_set   = 1'b1;
          end else begin
            w_next_state = ST_GAP;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Receive handshake, indices, gap counter and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rready <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_char   <= '0;
      r_gap    <= '0;
    end else begin
      r_rready <= rvalid & ~r_rready;
      r_done   <= w_done_set;
      r_abort  <= (r_state == ST_SEND) & ~w_hs & (r_abort | w_is_abort);

      if ((r_state == ST_IDLE) && w_is_start) begin
        r_wr_idx <= '0;
      end else if (w_wr_en) begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end

      if ((r_state == ST_CAPTURE) && (w_next_state == ST_GAP)) begin
        r_rd_idx <= '0;
        r_char   <= '0;
      end else if (w_hs) begin
        if (r_char == C_CHAR_CR) begin
          r_char   <= '0;
          r_rd_idx <= r_rd_idx + 1'b1;
        end else begin
          r_char <= r_char + 1'b1;
        end
      end

      if ((w_next_state == ST_GAP) && (r_state != ST_GAP)) begin
        r_gap <= C_GAP_LOAD;
      end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  // Sample buffer: contents deliberately survive reset; read runs every cycle
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_idx] <= sample_in;
    r_rd_data <= r_mem[r_rd_idx];
  end

  // Character select: hex nibble (MSB first), then LF, then CR
  always_comb begin
    w_nib  = 4'h0;
    w_char = 8'h00;
    for (int i = 0; i < NIB; i++) begin
      if (r_char == CW'(i)) w_nib = r_rd_data[4*(NIB-1-i) +: 4];
    end
    if (r_char == C_CHAR_LF) begin
      w_char = 8'h0A;
    end else if (r_char == C_CHAR_CR) begin
      w_char = 8'h0D;
    end else if (w_nib < 4'd10) begin
      w_char = 8'h30 + {4'h0, w_nib};
    end else begin
      w_char = 8'h37 + {4'h0, w_nib};
    end
  end

  assign rready = r_rready;
  assign tvalid = (r_state == ST_SEND);
  assign tdata  = (r_state == ST_SEND) ? w_char : 8'h00;
  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_dump_sequencer
//  Purpose  : Directed self-checking bench for capture_dump_sequencer
//             (DEPTH=4, GAP_CYCLES=3, SAMPLE_W=24).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_capture_dump_sequencer;

  localparam int SAMPLE_W   = 24;
  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                rvalid = 1'b0;
  logic [7:0]          rdata = 8'h00;
  logic                rready;
  logic                tvalid;
  logic [7:0]          tdata;
  logic                tready = 1'b0;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int done_cnt = 0;

  byte unsigned got_q[$];
  int           got_cyc[$];
  byte unsigned exp_q[$];

  capture_dump_sequencer #(
    .SAMPLE_W  (SAMPLE_W),
    .DEPTH     (DEPTH),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rready      (rready),
    .tvalid      (tvalid),
    .tdata       (tdata),
    .tready      (tready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Cycle counter for byte spacing
  always @(posedge clk) cycle <= cycle + 1;

  // Record completed transmit handshakes and done pulses mid-cycle
  always @(negedge clk) begin
    if (tvalid && tready) begin
      got_q.push_back(tdata);
      got_cyc.push_back(cycle);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte unsigned b, input bit with_smp, input logic [SAMPLE_W-1:0] smp);
    int n;
    rdata  = b;
    rvalid = 1'b1;
    tick();
    n = 1;
    while (!rready && n < 8) begin
      tick();
      n++;
    end
    check("rready_rise_latency", n, 1);
    if (with_smp) begin
      sample_in    = smp;
      sample_valid = 1'b1;
    end
    tick();
    rvalid       = 1'b0;
    sample_valid = 1'b0;
    check("rready_fall", rready, 1'b0);
  endtask

  task automatic send_sample(input logic [SAMPLE_W-1:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic capture4(input logic [SAMPLE_W-1:0] a, input logic [SAMPLE_W-1:0] b,
                          input logic [SAMPLE_W-1:0] c, input logic [SAMPLE_W-1:0] d);
    send_byte(8'h73, 1'b0, '0);
    send_sample(a);
    send_sample(b);
    send_sample(c);
    send_sample(d);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
    tick();
    tick();
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
  endtask

  task automatic clear_all();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic compare_dump(input string tag);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        if (i > 0) check($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1], 4);
      end
    end
  endtask

  initial begin
    int n;
    int tv_seen;

    // Reset state
    tick(); tick(); tick();
    check("rst_rready", rready, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata",  tdata,  8'h00);
    check("rst_busy",   busy,   1'b0);
    check("rst_done",   done,   1'b0);
    rst_n = 1'b1;
    tick();

    // Basic dump, tready high
    tready = 1'b1;
    clear_all();
    capture4(24'h0000AB, 24'h123456, 24'hFEDCBA, 24'h00000F);
    check("t1_busy_after_capture", busy, 1'b1);
    wait_idle("t1_idle_timeout", 400);
    push_line("0000AB"); push_line("123456"); push_line("FEDCBA"); push_line("00000F");
    compare_dump("t1");
    check("t1_done_pulses", done_cnt, 1);

    // Backpressure on the first byte
    tready = 1'b0;
    clear_all();
    capture4(24'h0789CD, 24'h000001, 24'h0ABCDE, 24'h05A5A5);
    n = 0;
    while (!tvalid && n < 50) begin
      tick();
      n++;
    end
    check("t2_tvalid_timeout", tvalid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t2_hold_tvalid%0d", i), tvalid, 1'b1);
      check($sformatf("t2_hold_tdata%0d", i), tdata, 8'h30);
      tick();
    end
    tready = 1'b1;
    wait_idle("t2_idle_timeout", 400);
    push_line("0789CD"); push_line("000001"); push_line("0ABCDE"); push_line("05A5A5");
    compare_dump("t2");
    check("t2_done_pulses", done_cnt, 1);

    // Abort during capture, then a fresh capture
    clear_all();
    send_byte(8'h73, 1'b0, '0);
    send_sample(24'hAAAAAA);
    send_sample(24'hBBBBBB);
    send_byte(8'h78, 1'b0, '0);
    check("t3_abort_idle", busy, 1'b0);
    tv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid) tv_seen++;
      tick();
    end
    check("t3_no_tvalid", tv_seen, 0);
    check("t3_no_bytes", got_q.size(), 0);
    capture4(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    wait_idle("t3_idle_timeout", 400);
    push_line("111111"); push_line("222222"); push_line("333333"); push_line("444444");
    compare_dump("t3");
    check("t3_done_pulses", done_cnt, 1);

    // Abort while byte 5 is held by backpressure
    clear_all();
    capture4(24'h13579B, 24'h2468AC, 24'h0F1E2D, 24'h3C4B5A);
    n = 0;
    while (got_q.size() < 4 && n < 200) begin
      tick();
      n++;
    end
    tready = 1'b0;
    check("t4_four_bytes", got_q.size(), 4);
    n = 0;
    while (!tvalid && n < 20) begin
      tick();
      n++;
    end
    check("t4_byte5_offered", tvalid, 1'b1);
    check("t4_byte5_data", tdata, 8'h39);
    send_byte(8'h78, 1'b0, '0);
    tick(); tick(); tick();
    check("t4_hold_tvalid", tvalid, 1'b1);
    check("t4_hold_tdata", tdata, 8'h39);
    check("t4_hold_busy", busy, 1'b1);
    tready = 1'b1;
    tick();
    check("t4_post_hs_tvalid", tvalid, 1'b0);
    check("t4_post_hs_busy", busy, 1'b0);
    tv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (tvalid) tv_seen++;
      tick();
    end
    check("t4_no_byte6", tv_seen, 0);
    push_line("13579B");
    check("t4_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check($sformatf("t4_byte%0d", i), got_q[i], exp_q[i]);
    end
    check("t4_done_low", done_cnt, 0);

    // Sample strobe coincident with the 's' consume is not stored
    clear_all();
    send_byte(8'h53, 1'b1, 24'h999999);
    send_sample(24'hDEAD00);
    send_sample(24'h0BEEF0);
    send_sample(24'h000C0D);
    send_sample(24'hCAFE12);
    wait_idle("t5_idle_timeout", 400);
    push_line("DEAD00"); push_line("0BEEF0"); push_line("000C0D"); push_line("CAFE12");
    compare_dump("t5");
    check("t5_done_pulses", done_cnt, 1);

    // Asynchronous reset in the gap before sample 2
    clear_all();
    capture4(24'h5A5A5A, 24'hC3C3C3, 24'h0000FF, 24'h123ABC);
    n = 0;
    while (got_q.size() < 8 && n < 200) begin
      tick();
      n++;
    end
    check("t6_eight_bytes", got_q.size(), 8);
    check("t6_busy_before_rst", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rready", rready, 1'b0);
    check("t6_rst_tvalid", tvalid, 1'b0);
    check("t6_rst_tdata",  tdata,  8'h00);
    check("t6_rst_busy",   busy,   1'b0);
    check("t6_rst_done",   done,   1'b0);
    tick();
    rst_n = 1'b1;
    tv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (tvalid) tv_seen++;
      tick();
    end
    check("t6_no_tvalid_after_rst", tv_seen, 0);
    check("t6_no_new_bytes", got_q.size(), 8);
    clear_all();
    capture4(24'h0A0B0C, 24'h0D0E0F, 24'h102030, 24'h405060);
    wait_idle("t6_idle_timeout", 400);
    push_line("0A0B0C"); push_line("0D0E0F"); push_line("102030"); push_line("405060");
    compare_dump("t6");
    check("t6_done_pulses", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
